sec_alert_handler: RTL and testbench
====================================

# sec_alert_handler

Consumer side of the security-alert interface produced by the execution-unit security monitor. It sits between the monitor and the ROB. Each cycle it accepts up to two per-lane alerts (aborted uop ROB index plus yrot) and buffers them in arrival order. It then issues them one at a time to the ROB as abort requests over a valid/ready handshake, waiting for the ROB's flush-done acknowledgment between requests.

## Interface
- DEPTH, 4: alert FIFO entries; power of two, ≥2
- ROB_IDX_W, 6: ROB index width
- YROT_W, 6: yrot width
- CNT_W, 16: statistics counter width
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_sec_alert_alert_valid  in  1  any lane alerting (informational, not used for qualification)
- io_sec_alert_alert_mask  in  2  per-lane alert bits
- io_sec_alert_aborted_uop_valid_0/_1  in  1 each  lane alert valid
- io_sec_alert_aborted_uop_rob_idx_0/_1  in  ROB_IDX_W each  offending uop ROB index
- io_sec_alert_aborted_uop_yrot_0/_1  in  YROT_W each  offending uop yrot
- io_kill  in  1  ROB rollback/exception; discards all pending alerts
- io_abort_valid  out  1  abort request to ROB
- io_abort_ready  in  1  ROB accepts request
- io_abort_rob_idx  out  ROB_IDX_W  request ROB index
- io_abort_yrot  out  YROT_W  request yrot
- io_abort_lane  out  1  originating lane
- io_flush_done  in  1  ROB finished servicing the accepted abort
- io_busy  out  1  FIFO non-empty or FSM not IDLE
- io_overflow  out  1  sticky: an alert was dropped
- io_overflow_clear  in  1  clears io_overflow
- io_alert_count  out  CNT_W  alerts enqueued, saturating
- io_drop_count  out  CNT_W  alerts dropped, saturating

## Operation
- Lane n qualifies when aborted_uop_valid_n && alert_mask[n]. If either bit is low, the lane is ignored and nothing is counted.
- When both lanes qualify in the same cycle, lane 0 is enqueued before lane 1.
- Admission is checked against the free slots at the start of the cycle. A same-cycle pop does not free a slot for that cycle.
  - With one free slot, lane 0 is accepted and lane 1 is dropped.
  - With zero free slots, both lanes are dropped.
  - Each dropped alert sets io_overflow and increments io_drop_count.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE → ISSUE when the FIFO is non-empty.
  - ISSUE: io_abort_valid=1 and the payload is driven from the FIFO head.
  - On io_abort_ready, the head is popped and the FSM moves to WAIT_DONE.
  - WAIT_DONE → IDLE on io_flush_done. io_flush_done is ignored in the other states.
- io_kill, in any state:
  - Empties the FIFO; the FSM goes to IDLE the next cycle.
  - Same-cycle incoming alerts are discarded and not counted as drops.
  - A handshake in the same cycle still counts as accepted by the ROB. The FIFO is nevertheless cleared and the FSM goes to IDLE, not WAIT_DONE.
- Counters saturate at all-ones and never wrap.
- io_overflow_clear has priority over a same-cycle set, but the drop is still counted.

## Timing
- Reset values:
  - io_abort_valid, io_abort_rob_idx, io_abort_yrot, io_abort_lane, io_busy, io_overflow = 0
  - both counters = 0
  - FIFO empty, FSM IDLE
- All outputs are registered.
- Latency: an alert enqueued at edge t raises io_abort_valid after edge t+1 at the earliest (IDLE→ISSUE takes one cycle).
- Handshake: once io_abort_valid is asserted, the payload is stable and io_abort_valid stays high until the io_abort_ready cycle. io_abort_valid drops the cycle after acceptance.
- Back-to-back requests are spaced by at least WAIT_DONE plus one IDLE cycle.
- FIFO pointers are log2(DEPTH) bits, with an extra wrap bit for full/empty.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). An outstanding ROB handshake is abandoned.

## Structure
- Shared package (sec_alert_pkg):
  - alert entry struct: rob_idx, yrot, lane
  - FSM state enum
  - ROB_IDX_W and YROT_W defaults
- One sub-module: sec_alert_fifo, a DEPTH-entry FIFO with 2-wide enqueue, 1-wide dequeue, flush input, and a free-count output. The FSM, handshake and counters live in the top module.

## Test plan
- Lane 0 only, rob_idx=0x05, yrot=0x03, ready held high → io_abort_valid after edge t+1 with 0x05/0x03, lane=0; io_alert_count=1; io_busy low after io_flush_done.
- Both lanes in one cycle, rob_idx 0x0A/0x0B → requests issued in order 0x0A (lane 0) then 0x0B (lane 1); the second request appears only after io_flush_done for the first.
- io_abort_ready held low for 5 cycles → io_abort_valid and payload stable for all 5 cycles; exactly one pop on acceptance.
- DEPTH=4 with ready low: 2+2 alerts fill the FIFO, then 2 more alerts → both dropped; io_overflow=1, io_drop_count=2. io_overflow_clear then drops io_overflow to 0 while io_drop_count stays 2.
- 3 alerts pending, io_kill asserted together with a new lane-0 alert → FIFO empty, FSM IDLE the next cycle, no abort issued, io_alert_count unchanged by the killed-cycle alert.
- reset_n pulsed low during ISSUE → all outputs 0 asynchronously; after release, a fresh alert is issued normally.

Source files
------------

// File: rtl/sec_alert_pkg.sv
// Shared types for the security-alert consumer: default field widths,
// the buffered alert entry layout and the issue FSM states.
package sec_alert_pkg;

    localparam int unsigned DEF_ROB_IDX_W = 6;
    localparam int unsigned DEF_YROT_W    = 6;

    typedef struct packed {
        logic [DEF_ROB_IDX_W-1:0] rob_idx;
        logic [DEF_YROT_W-1:0]    yrot;
        logic                     lane;
    } alert_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sec_alert_fifo.sv
// Alert buffer: DEPTH entries, up to two writes and one read per cycle,
// synchronous flush, and a free-slot count for admission decisions.
module sec_alert_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 13
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push_0,
    input  logic [W-1:0]             data_0,
    input  logic                     push_1,
    input  logic [W-1:0]             data_1,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   count;
    logic [AW-1:0] waddr_0;
    logic [AW-1:0] waddr_1;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign count      = wptr - rptr;
    assign empty      = (count == '0);
    assign free_count = (AW+1)'(DEPTH) - count;
    assign head       = mem[rptr[AW-1:0]];
    assign waddr_0    = wptr[AW-1:0];
    assign waddr_1    = waddr_0 + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(push_0) + (AW+1)'(push_1);
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // A lone lane-1 write lands in the first free slot, keeping arrival order.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (push_0) begin
                mem[waddr_0] <= data_0;
            end
            if (push_1) begin
                mem[push_0 ? waddr_1 : waddr_0] <= data_1;
            end
        end
    end

endmodule

// File: rtl/sec_alert_handler.sv
// Buffers per-lane security alerts and issues them one at a time to the ROB
// as abort requests, waiting for flush-done between requests.
module sec_alert_handler
    import sec_alert_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ROB_IDX_W = sec_alert_pkg::DEF_ROB_IDX_W,
    parameter int unsigned YROT_W    = sec_alert_pkg::DEF_YROT_W,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 io_sec_alert_alert_valid,
    input  logic [1:0]           io_sec_alert_alert_mask,
    input  logic                 io_sec_alert_aborted_uop_valid_0,
    input  logic                 io_sec_alert_aborted_uop_valid_1,
    input  logic [ROB_IDX_W-1:0] io_sec_alert_aborted_uop_rob_idx_0,
    input  logic [ROB_IDX_W-1:0] io_sec_alert_aborted_uop_rob_idx_1,
    input  logic [YROT_W-1:0]    io_sec_alert_aborted_uop_yrot_0,
    input  logic [YROT_W-1:0]    io_sec_alert_aborted_uop_yrot_1,
    input  logic                 io_kill,
    output logic                 io_abort_valid,
    input  logic                 io_abort_ready,
    output logic [ROB_IDX_W-1:0] io_abort_rob_idx,
    output logic [YROT_W-1:0]    io_abort_yrot,
    output logic                 io_abort_lane,
    input  logic                 io_flush_done,
    output logic                 io_busy,
    output logic                 io_overflow,
    input  logic                 io_overflow_clear,
    output logic [CNT_W-1:0]     io_alert_count,
    output logic [CNT_W-1:0]     io_drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = ROB_IDX_W + YROT_W + 1;

    logic          unused_alert_valid;
    logic          qual_0;
    logic          qual_1;
    logic          acc_0;
    logic          acc_1;
    logic          pop;
    logic          fifo_empty;
    logic          load_payload;
    logic [1:0]    n_enq;
    logic [1:0]    n_drop;
    logic [AW:0]   free;
    logic [AW:0]   count;
    logic [AW:0]   count_d;
    logic [EW-1:0] head;
    logic [EW-1:0] data_0;
    logic [EW-1:0] data_1;
    state_t        state_q;
    state_t        state_d;

    assign unused_alert_valid = io_sec_alert_alert_valid;

    assign qual_0 = io_sec_alert_aborted_uop_valid_0 & io_sec_alert_alert_mask[0];
    assign qual_1 = io_sec_alert_aborted_uop_valid_1 & io_sec_alert_alert_mask[1];

    // Admission uses start-of-cycle free slots; lane 0 always claims first.
    assign acc_0 = qual_0 & ~io_kill & (free != '0);
    assign acc_1 = qual_1 & ~io_kill &
                   (qual_0 ? (free >= (AW+1)'(2)) : (free != '0));

    assign n_enq  = {1'b0, acc_0} + {1'b0, acc_1};
    assign n_drop = {1'b0, qual_0 & ~io_kill & ~acc_0} +
                    {1'b0, qual_1 & ~io_kill & ~acc_1};

    assign data_0 = {io_sec_alert_aborted_uop_rob_idx_0, io_sec_alert_aborted_uop_yrot_0, 1'b0};
    assign data_1 = {io_sec_alert_aborted_uop_rob_idx_1, io_sec_alert_aborted_uop_yrot_1, 1'b1};

    assign pop     = (state_q == ST_ISSUE) & io_abort_ready;
    assign count   = (AW+1)'(DEPTH) - free;
    assign count_d = io_kill ? '0 : (count + (AW+1)'(n_enq) - (AW+1)'(pop));

    sec_alert_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (io_kill),
        .push_0     (acc_0),
        .data_0     (data_0),
        .push_1     (acc_1),
        .data_1     (data_1),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .free_count (free)
    );

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        load_payload = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d      = ST_ISSUE;
                    load_payload = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (io_abort_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (io_flush_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Kill wins even over a same-cycle handshake: no WAIT_DONE follows.
        if (io_kill) begin
            state_d      = ST_IDLE;
            load_payload = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            io_abort_valid   <= 1'b0;
            io_abort_rob_idx <= '0;
            io_abort_yrot    <= '0;
            io_abort_lane    <= 1'b0;
            io_busy          <= 1'b0;
            io_overflow      <= 1'b0;
            io_alert_count   <= '0;
            io_drop_count    <= '0;
        end else begin
            state_q        <= state_d;
            io_abort_valid <= (state_d == ST_ISSUE);
            if (load_payload) begin
                {io_abort_rob_idx, io_abort_yrot, io_abort_lane} <= head;
            end
            io_busy <= (count_d != '0) || (state_d != ST_IDLE);
            if (io_overflow_clear) begin
                io_overflow <= 1'b0;
            end else if (n_drop != 2'd0) begin
                io_overflow <= 1'b1;
            end
            io_alert_count <= sat_add(io_alert_count, n_enq);
            io_drop_count  <= sat_add(io_drop_count, n_drop);
        end
    end

endmodule

// File: tb/tb_sec_alert_handler.sv
// Bench for sec_alert_handler: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the alert rules.
module tb_sec_alert_handler;

    localparam int DEPTH = 4;
    localparam int RW    = 6;
    localparam int YW    = 6;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          alert_valid;
    logic [1:0]    mask;
    logic          v0, v1;
    logic [RW-1:0] r0, r1;
    logic [YW-1:0] y0, y1;
    logic          kill, ready, flush_done, ovf_clear;
    logic          a_valid;
    logic [RW-1:0] a_rob;
    logic [YW-1:0] a_yrot;
    logic          a_lane;
    logic          busy, ovf;
    logic [CW-1:0] acnt, dcnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [RW-1:0] rob;
        logic [YW-1:0] yrot;
        logic          lane;
    } ent_t;

    // Reference model: pending alerts in order, the request on offer, and
    // the service phase (0 nothing outstanding, 1 offered, 2 awaiting flush).
    ent_t mq[$];
    ent_t cur;
    int   phase  = 0;
    int   m_acnt = 0;
    int   m_dcnt = 0;
    bit   m_ovf  = 1'b0;

    always #5 clock = ~clock;

    sec_alert_handler #(
        .DEPTH     (DEPTH),
        .ROB_IDX_W (RW),
        .YROT_W    (YW),
        .CNT_W     (CW)
    ) dut (
        .clock                              (clock),
        .reset_n                            (reset_n),
        .io_sec_alert_alert_valid           (alert_valid),
        .io_sec_alert_alert_mask            (mask),
        .io_sec_alert_aborted_uop_valid_0   (v0),
        .io_sec_alert_aborted_uop_valid_1   (v1),
        .io_sec_alert_aborted_uop_rob_idx_0 (r0),
        .io_sec_alert_aborted_uop_rob_idx_1 (r1),
        .io_sec_alert_aborted_uop_yrot_0    (y0),
        .io_sec_alert_aborted_uop_yrot_1    (y1),
        .io_kill                            (kill),
        .io_abort_valid                     (a_valid),
        .io_abort_ready                     (ready),
        .io_abort_rob_idx                   (a_rob),
        .io_abort_yrot                      (a_yrot),
        .io_abort_lane                      (a_lane),
        .io_flush_done                      (flush_done),
        .io_busy                            (busy),
        .io_overflow                        (ovf),
        .io_overflow_clear                  (ovf_clear),
        .io_alert_count                     (acnt),
        .io_drop_count                      (dcnt)
    );

    task automatic model_reset();
        mq.delete();
        phase  = 0;
        m_acnt = 0;
        m_dcnt = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic clear_in();
        v0 = 1'b0; v1 = 1'b0; mask = 2'b00; alert_valid = 1'b0;
        r0 = '0; r1 = '0; y0 = '0; y1 = '0;
        kill = 1'b0; flush_done = 1'b0; ovf_clear = 1'b0;
    endtask

    task automatic set_lanes(input logic l0, input logic [RW-1:0] ra, input logic [YW-1:0] ya,
                             input logic l1, input logic [RW-1:0] rb, input logic [YW-1:0] yb);
        v0 = l0; v1 = l1; mask = {l1, l0}; alert_valid = l0 | l1;
        r0 = ra; y0 = ya; r1 = rb; y1 = yb;
    endtask

    // Advance the model by one cycle using the inputs the DUT is about to
    // sample, then let the clock edge happen and settle.
    task automatic tick();
        int         free_slots;
        int         drops;
        logic [1:0] qual;
        ent_t       inc [2];
        qual[0] = v0 & mask[0];
        qual[1] = v1 & mask[1];
        inc[0].rob = r0; inc[0].yrot = y0; inc[0].lane = 1'b0;
        inc[1].rob = r1; inc[1].yrot = y1; inc[1].lane = 1'b1;
        free_slots = DEPTH - mq.size();
        drops = 0;
        if (kill) begin
            mq.delete();
            phase = 0;
        end else begin
            if (phase == 0) begin
                if (mq.size() > 0) begin
                    phase = 1;
                    cur = mq[0];
                end
            end else if (phase == 1) begin
                if (ready) begin
                    mq.delete(0);
                    phase = 2;
                end
            end else if (flush_done) begin
                phase = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (qual[i]) begin
                    if (free_slots > 0) begin
                        mq.push_back(inc[i]);
                        free_slots--;
                        if (m_acnt < CMAX) m_acnt++;
                    end else begin
                        drops++;
                        if (m_dcnt < CMAX) m_dcnt++;
                    end
                end
            end
        end
        if (ovf_clear) m_ovf = 1'b0;
        else if (drops > 0) m_ovf = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n;
        clear_in();
        ready = 1'b1;
        flush_done = 1'b1;
        n = 0;
        while ((busy || phase != 0 || mq.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: busy=%b after %0d cycles, required 0", busy, n);
        end
        clear_in();
    endtask

    task automatic test_reset();
        clear_in();
        ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({a_valid, a_rob, a_yrot, a_lane, busy, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b rob=%0h yrot=%0h lane=%b busy=%b ovf=%b, required all 0",
                     a_valid, a_rob, a_yrot, a_lane, busy, ovf);
        end
        checks++;
        if (acnt !== '0 || dcnt !== '0) begin
            errors++;
            $display("FAIL reset_counters: got alert=%0d drop=%0d, required 0/0", acnt, dcnt);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        clear_in();
        ready = 1'b1;
        set_lanes(1'b1, 6'h05, 6'h03, 1'b0, '0, '0);
        tick();
        clear_in();
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: valid=%b right after enqueue edge, required 0", a_valid);
        end
        tick();
        checks++;
        if (a_valid !== 1'b1 || a_rob !== 6'h05 || a_yrot !== 6'h03 || a_lane !== 1'b0) begin
            errors++;
            $display("FAIL single_request: got valid=%b rob=%0h yrot=%0h lane=%b, required 1/05/03/0",
                     a_valid, a_rob, a_yrot, a_lane);
        end
        checks++;
        if (acnt !== 8'd1) begin
            errors++;
            $display("FAIL single_count: alert_count=%0d, required 1", acnt);
        end
        tick();
        checks++;
        if (a_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got valid=%b busy=%b, required 0/1", a_valid, busy);
        end
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b after flush_done, required 0", busy);
        end
    endtask

    task automatic test_dual_order();
        clear_in();
        ready = 1'b1;
        set_lanes(1'b1, 6'h0A, 6'h01, 1'b1, 6'h0B, 6'h02);
        tick();
        clear_in();
        tick();
        checks++;
        if (a_valid !== 1'b1 || a_rob !== 6'h0A || a_lane !== 1'b0) begin
            errors++;
            $display("FAIL dual_first: got valid=%b rob=%0h lane=%b, required 1/0a/0", a_valid, a_rob, a_lane);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_valid !== 1'b0) begin
                errors++;
                $display("FAIL dual_hold: valid=%b before flush_done (cycle %0d), required 0", a_valid, i);
            end
        end
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
        tick();
        checks++;
        if (a_valid !== 1'b1 || a_rob !== 6'h0B || a_yrot !== 6'h02 || a_lane !== 1'b1) begin
            errors++;
            $display("FAIL dual_second: got valid=%b rob=%0h yrot=%0h lane=%b, required 1/0b/02/1",
                     a_valid, a_rob, a_yrot, a_lane);
        end
        drain();
    endtask

    task automatic test_stall();
        clear_in();
        ready = 1'b0;
        set_lanes(1'b1, 6'h15, 6'h2A, 1'b0, '0, '0);
        tick();
        clear_in();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (a_valid !== 1'b1 || a_rob !== 6'h15 || a_yrot !== 6'h2A || a_lane !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable: cycle %0d got valid=%b rob=%0h yrot=%0h, required 1/15/2a",
                         i, a_valid, a_rob, a_yrot);
            end
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (a_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got valid=%b busy=%b, required 0/1", a_valid, busy);
        end
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || acnt !== m_acnt[CW-1:0]) begin
            errors++;
            $display("FAIL stall_single_pop: got busy=%b alert_count=%0d, required 0/%0d", busy, acnt, m_acnt);
        end
    endtask

    task automatic test_overflow();
        clear_in();
        ready = 1'b0;
        set_lanes(1'b1, 6'h20, 6'h00, 1'b1, 6'h21, 6'h01);
        tick();
        set_lanes(1'b1, 6'h22, 6'h02, 1'b1, 6'h23, 6'h03);
        tick();
        set_lanes(1'b1, 6'h24, 6'h04, 1'b1, 6'h25, 6'h05);
        tick();
        clear_in();
        checks++;
        if (ovf !== 1'b1 || dcnt !== 8'd2) begin
            errors++;
            $display("FAIL ovf_full_drop: got overflow=%b drop_count=%0d, required 1/2", ovf, dcnt);
        end
        ovf_clear = 1'b1;
        tick();
        checks++;
        if (ovf !== 1'b0 || dcnt !== 8'd2) begin
            errors++;
            $display("FAIL ovf_clear: got overflow=%b drop_count=%0d, required 0/2", ovf, dcnt);
        end
        set_lanes(1'b1, 6'h2F, 6'h0F, 1'b0, '0, '0);
        tick();
        clear_in();
        checks++;
        if (ovf !== 1'b0 || dcnt !== 8'd3) begin
            errors++;
            $display("FAIL ovf_clear_priority: got overflow=%b drop_count=%0d, required 0/3", ovf, dcnt);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        set_lanes(1'b1, 6'h26, 6'h06, 1'b1, 6'h27, 6'h07);
        tick();
        clear_in();
        checks++;
        if (ovf !== 1'b1 || dcnt !== 8'd4 || acnt !== m_acnt[CW-1:0]) begin
            errors++;
            $display("FAIL ovf_one_slot: got overflow=%b drop=%0d alert=%0d, required 1/4/%0d",
                     ovf, dcnt, acnt, m_acnt);
        end
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
        tick();
        checks++;
        if (a_valid !== 1'b1 || a_rob !== 6'h21 || a_lane !== 1'b1) begin
            errors++;
            $display("FAIL ovf_next_head: got valid=%b rob=%0h lane=%b, required 1/21/1", a_valid, a_rob, a_lane);
        end
        drain();
    endtask

    task automatic test_kill();
        int saved;
        clear_in();
        ready = 1'b0;
        set_lanes(1'b1, 6'h30, 6'h10, 1'b1, 6'h31, 6'h11);
        tick();
        set_lanes(1'b1, 6'h32, 6'h12, 1'b0, '0, '0);
        tick();
        clear_in();
        tick();
        checks++;
        if (a_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL kill_setup: got valid=%b busy=%b, required 1/1", a_valid, busy);
        end
        saved = m_acnt;
        kill = 1'b1;
        set_lanes(1'b1, 6'h33, 6'h13, 1'b0, '0, '0);
        tick();
        clear_in();
        checks++;
        if (a_valid !== 1'b0 || busy !== 1'b0 || acnt !== saved[CW-1:0] || dcnt !== 8'd4) begin
            errors++;
            $display("FAIL kill_flush: got valid=%b busy=%b alert=%0d drop=%0d, required 0/0/%0d/4",
                     a_valid, busy, acnt, dcnt, saved);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (a_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL kill_quiet: cycle %0d got valid=%b busy=%b, required 0/0", i, a_valid, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_in();
        ready = 1'b0;
        set_lanes(1'b1, 6'h3C, 6'h3D, 1'b0, '0, '0);
        tick();
        clear_in();
        tick();
        checks++;
        if (a_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: valid=%b, required 1", a_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_rob, a_yrot, a_lane, busy, ovf, acnt, dcnt} !== '0) begin
            errors++;
            $display("FAIL areset_outputs: got valid=%b rob=%0h yrot=%0h lane=%b busy=%b ovf=%b alert=%0d drop=%0d, required all 0",
                     a_valid, a_rob, a_yrot, a_lane, busy, ovf, acnt, dcnt);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        ready = 1'b1;
        set_lanes(1'b0, '0, '0, 1'b1, 6'h33, 6'h11);
        tick();
        clear_in();
        tick();
        checks++;
        if (a_valid !== 1'b1 || a_rob !== 6'h33 || a_yrot !== 6'h11 || a_lane !== 1'b1 || acnt !== 8'd1) begin
            errors++;
            $display("FAIL areset_fresh: got valid=%b rob=%0h yrot=%0h lane=%b alert=%0d, required 1/33/11/1/1",
                     a_valid, a_rob, a_yrot, a_lane, acnt);
        end
        drain();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            v0 = 1'($urandom % 2);
            v1 = 1'($urandom % 2);
            mask = 2'($urandom % 4);
            alert_valid = v0 | v1;
            r0 = RW'($urandom); r1 = RW'($urandom);
            y0 = YW'($urandom); y1 = YW'($urandom);
            kill = ($urandom % 16) == 0;
            ready = 1'($urandom % 2);
            flush_done = 1'($urandom % 2);
            ovf_clear = ($urandom % 16) == 0;
            tick();
            checks++;
            if (a_valid !== (phase == 1)) begin
                errors++;
                $display("FAIL rand_valid: cycle %0d got %b, required %b", n, a_valid, phase == 1);
            end
            if (phase == 1) begin
                checks++;
                if (a_rob !== cur.rob || a_yrot !== cur.yrot || a_lane !== cur.lane) begin
                    errors++;
                    $display("FAIL rand_payload: cycle %0d got %0h/%0h/%b, required %0h/%0h/%b",
                             n, a_rob, a_yrot, a_lane, cur.rob, cur.yrot, cur.lane);
                end
            end
            checks++;
            if (busy !== (mq.size() != 0 || phase != 0)) begin
                errors++;
                $display("FAIL rand_busy: cycle %0d got %b, required %b", n, busy, mq.size() != 0 || phase != 0);
            end
            checks++;
            if (ovf !== m_ovf || acnt !== m_acnt[CW-1:0] || dcnt !== m_dcnt[CW-1:0]) begin
                errors++;
                $display("FAIL rand_status: cycle %0d got ovf=%b alert=%0d drop=%0d, required %b/%0d/%0d",
                         n, ovf, acnt, dcnt, m_ovf, m_acnt, m_dcnt);
            end
        end
        drain();
    endtask

    task automatic test_saturation();
        clear_in();
        ready = 1'b0;
        for (int i = 0; i < 140; i++) begin
            set_lanes(1'b1, RW'(i), YW'(i), 1'b1, RW'(i + 1), YW'(i + 1));
            tick();
        end
        clear_in();
        checks++;
        if (dcnt !== 8'hFF || m_dcnt != CMAX) begin
            errors++;
            $display("FAIL sat_drop: drop_count=%0d, required %0d", dcnt, CMAX);
        end
        drain();
        ready = 1'b0;
        for (int i = 0; i < 140; i++) begin
            set_lanes(1'b1, RW'(i), YW'(i), 1'b1, RW'(i + 2), YW'(i + 2));
            tick();
            clear_in();
            kill = 1'b1;
            tick();
            kill = 1'b0;
        end
        checks++;
        if (acnt !== 8'hFF || dcnt !== 8'hFF || m_acnt != CMAX) begin
            errors++;
            $display("FAIL sat_alert: got alert=%0d drop=%0d, required %0d/%0d", acnt, dcnt, CMAX, CMAX);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_order();
        test_stall();
        test_overflow();
        test_kill();
        test_async_reset();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
